// File: rtl/rock_step_sequencer.sv
// rock_step_sequencer: measures a stress baseline, requests one rocking step
// from the path finder, waits for the baby to settle, measures a window
// average and compares it with the baseline. Counts consecutive failures
// and raises a sticky alarm after MAX_FAIL of them.
module rock_step_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned WIN_LOG2      = 4,
  parameter int unsigned MAX_FAIL      = 7,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       sample_valid,
  input  logic [7:0] huilVolume,
  input  logic [7:0] hartRitme,
  input  logic       step_ack,
  output logic       step_req,
  output logic       stress_dropped,
  output logic       alarm,
  output logic [2:0] fail_count,
  output logic [8:0] stress_avg,
  output logic       busy
);

  localparam int unsigned ACC_W = 9 + WIN_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BASELINE,
    S_REQ,
    S_SETTLE,
    S_MEASURE,
    S_EVAL,
    S_ALARM
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [WIN_LOG2-1:0] smp_cnt_q, smp_cnt_d;
  logic [CNT_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic [8:0]          baseline_q, baseline_d;
  logic [8:0]          stress_avg_q, stress_avg_d;
  logic [2:0]          fail_count_q, fail_count_d;
  logic                step_req_q, step_req_d;
  logic                stress_dropped_q, stress_dropped_d;
  logic                alarm_q, alarm_d;
  logic                busy_q, busy_d;

  logic [8:0]          sample_s;
  logic [ACC_W-1:0]    acc_sum;
  logic [8:0]          win_avg;
  logic                win_last;
  logic [3:0]          fail_inc;

  // Next-state, datapath and registered-output computation
  always_comb begin
    sample_s         = {1'b0, huilVolume} + {1'b0, hartRitme};
    acc_sum          = acc_q + ACC_W'(sample_s);
    win_avg          = acc_sum[ACC_W-1:WIN_LOG2];
    win_last         = sample_valid && (smp_cnt_q == '1);
    fail_inc         = {1'b0, fail_count_q} + 4'd1;

    state_d          = state_q;
    acc_d            = acc_q;
    smp_cnt_d        = smp_cnt_q;
    settle_cnt_d     = settle_cnt_q;
    baseline_d       = baseline_q;
    stress_avg_d     = stress_avg_q;
    fail_count_d     = fail_count_q;
    stress_dropped_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        acc_d        = '0;
        smp_cnt_d    = '0;
        settle_cnt_d = '0;
        if (enable) state_d = S_BASELINE;
      end

      S_BASELINE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (sample_valid) begin
          if (win_last) begin
            baseline_d   = win_avg;
            stress_avg_d = win_avg;
            acc_d        = '0;
            smp_cnt_d    = '0;
            state_d      = S_REQ;
          end else begin
            acc_d     = acc_sum;
            smp_cnt_d = smp_cnt_q + WIN_LOG2'(1);
          end
        end
      end

      S_REQ: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (step_ack && step_req_q) begin
          settle_cnt_d = '0;
          state_d      = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (settle_cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          settle_cnt_d = '0;
          acc_d        = '0;
          smp_cnt_d    = '0;
          state_d      = S_MEASURE;
        end else begin
          settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end

      S_MEASURE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (sample_valid) begin
          if (win_last) begin
            // The drop pulse is registered here so it is visible during EVAL,
            // using the same comparison EVAL applies to the stored average.
            stress_avg_d     = win_avg;
            stress_dropped_d = (win_avg < baseline_q);
            acc_d            = '0;
            smp_cnt_d        = '0;
            state_d          = S_EVAL;
          end else begin
            acc_d     = acc_sum;
            smp_cnt_d = smp_cnt_q + WIN_LOG2'(1);
          end
        end
      end

      S_EVAL: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (stress_avg_q < baseline_q) begin
          baseline_d   = stress_avg_q;
          fail_count_d = '0;
          state_d      = S_REQ;
        end else if (fail_inc == 4'(MAX_FAIL)) begin
          fail_count_d = 3'(MAX_FAIL);
          state_d      = S_ALARM;
        end else begin
          fail_count_d = fail_inc[2:0];
          state_d      = S_REQ;
        end
      end

      S_ALARM: begin
        state_d = S_ALARM;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    step_req_d = (state_d == S_REQ);
    alarm_d    = (state_d == S_ALARM);
    busy_d     = (state_d != S_IDLE) && (state_d != S_ALARM);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      acc_q            <= '0;
      smp_cnt_q        <= '0;
      settle_cnt_q     <= '0;
      baseline_q       <= '0;
      stress_avg_q     <= '0;
      fail_count_q     <= '0;
      step_req_q       <= 1'b0;
      stress_dropped_q <= 1'b0;
      alarm_q          <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      acc_q            <= acc_d;
      smp_cnt_q        <= smp_cnt_d;
      settle_cnt_q     <= settle_cnt_d;
      baseline_q       <= baseline_d;
      stress_avg_q     <= stress_avg_d;
      fail_count_q     <= fail_count_d;
      step_req_q       <= step_req_d;
      stress_dropped_q <= stress_dropped_d;
      alarm_q          <= alarm_d;
      busy_q           <= busy_d;
    end
  end

  assign step_req       = step_req_q;
  assign stress_dropped = stress_dropped_q;
  assign alarm          = alarm_q;
  assign fail_count     = fail_count_q;
  assign stress_avg     = stress_avg_q;
  assign busy           = busy_q;

endmodule
